// File: rtl/game_timer.sv
// game_timer: prescaled game clock with whack capture and threshold / terminal-count edge pulses.
// Define GAME_TIMER_LAP_EN for lap capture (count keeps running); by default the first whack freezes the count.
module game_timer #(
  parameter int CNT_W     = 10,
  parameter int TICK_DIV  = 500000,
  parameter int MAX_COUNT = 999,
  parameter int N_THR     = 4,
  parameter int WRAP      = 0
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_restart,
  input  logic                   i_pause,
  input  logic                   i_whack,
  input  logic [N_THR*CNT_W-1:0] i_thr,
  output logic [CNT_W-1:0]       o_display_timer,
  output logic [CNT_W-1:0]       o_timer_stop,
  output logic                   o_stop_valid,
  output logic [N_THR-1:0]       o_thr_edge,
  output logic                   o_max_edge
);

  localparam int                 PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]      PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(MAX_COUNT);
`ifdef GAME_TIMER_LAP_EN
  localparam bit                 LAP_EN     = 1'b1;
`else
  localparam bit                 LAP_EN     = 1'b0;
`endif

  typedef enum logic [1:0] {S_RUN, S_PAUSED, S_FROZEN, S_DONE} state_t;

  state_t           r_state;
  logic [PW-1:0]    r_presc;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_timer_stop;
  logic             r_stop_valid;
  logic [N_THR-1:0] r_thr_eq;
  logic [N_THR-1:0] r_thr_edge;
  logic             r_max_eq;
  logic             r_max_edge;

  logic             w_active;
  logic             w_tick;
  logic             w_cap;
  logic [N_THR-1:0] w_thr_eq;
  logic             w_max_eq;

  // Pause is a level: counting resumes in the same cycle pause drops.
  assign w_active = (r_state == S_RUN) || (r_state == S_PAUSED);
  assign w_tick   = w_active && !i_pause && (r_presc == PRESC_LAST);
  assign w_cap    = w_active && i_whack;

  always_comb begin
    w_thr_eq = '0;
    for (int i = 0; i < N_THR; i++) begin
      w_thr_eq[i] = (r_count == i_thr[i*CNT_W +: CNT_W]);
    end
  end

  assign w_max_eq = (r_count == CNT_MAX);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= S_RUN;
      r_presc      <= '0;
      r_count      <= '0;
      r_timer_stop <= '0;
      r_stop_valid <= 1'b0;
    end else if (i_restart) begin
      r_state      <= S_RUN;
      r_presc      <= '0;
      r_count      <= '0;
      r_stop_valid <= 1'b0;
    end else begin
      r_stop_valid <= w_cap;
      if (w_cap) begin
        r_timer_stop <= r_count;
      end
      // A freezing capture also swallows a coincident tick.
      if (w_cap && !LAP_EN) begin
        r_state <= S_FROZEN;
      end else if (w_active) begin
        if (!i_pause) begin
          r_presc <= w_tick ? '0 : r_presc + 1'b1;
        end
        if (w_tick && (r_count == CNT_MAX) && (WRAP == 0)) begin
          r_state <= S_DONE;
        end else begin
          r_state <= i_pause ? S_PAUSED : S_RUN;
        end
        if (w_tick) begin
          if (r_count != CNT_MAX) begin
            r_count <= r_count + 1'b1;
          end else if (WRAP != 0) begin
            r_count <= '0;
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_thr_eq   <= '0;
      r_thr_edge <= '0;
      r_max_eq   <= 1'b0;
      r_max_edge <= 1'b0;
    end else begin
      r_thr_eq   <= w_thr_eq;
      r_thr_edge <= w_thr_eq & ~r_thr_eq;
      r_max_eq   <= w_max_eq;
      r_max_edge <= w_max_eq & ~r_max_eq;
    end
  end

  assign o_display_timer = r_count;
  assign o_timer_stop    = r_timer_stop;
  assign o_stop_valid    = r_stop_valid;
  assign o_thr_edge      = r_thr_edge;
  assign o_max_edge      = r_max_edge;

endmodule
